// File: rtl/key_loader.sv
// Key register initiator: pulls 64-bit key words from a stream, writes them to the
// tag engine's key registers, optionally reads each one back, then pulses start.
module key_loader #(
  parameter int          pADDR_WIDTH = 32,
  parameter int          pDATA_WIDTH = 64,
  parameter int          NUM_KEYS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_STRIDE = 8,
  parameter bit          VERIFY      = 1'b1,
  parameter int          RD_TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [pDATA_WIDTH-1:0] ks_tdata,
  input  logic                   ks_tvalid,
  output logic                   ks_tready,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             err_index
);

  localparam int TW    = $clog2(RD_TIMEOUT + 1);
  localparam int LANES = pDATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_RADDR,
    S_RDATA,
    S_PULSE,
    S_ERR
  } state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             idx_reg;
  logic [TW-1:0]          tmo_reg;
  logic [pADDR_WIDTH-1:0] awaddr_reg, araddr_reg;
  logic [pDATA_WIDTH-1:0] wdata_reg;
  logic                   ks_tready_reg, awvalid_reg, wvalid_reg, arvalid_reg, rready_reg;
  logic                   start_reg, busy_reg, done_reg, error_reg;
  logic [2:0]             err_index_reg;

  logic                   last_word;
  logic                   wr_accept;
  logic                   tmo_hit;
  logic                   rd_match;
  logic [LANES-1:0]       lane_eq;

  // Readback compare split into byte lanes so the wide equality maps onto
  // small LUT trees feeding a single AND reduction.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_eq[gi] = (rdata[gi*8 +: 8] == wdata_reg[gi*8 +: 8]);
    end
  endgenerate

  assign rd_match  = &lane_eq;
  assign last_word = (idx_reg == 3'(NUM_KEYS - 1));
  assign wr_accept = awready && wready;
  assign tmo_hit   = (tmo_reg == TW'(RD_TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (load) state_next = S_FETCH;
      S_FETCH: if (ks_tvalid) state_next = S_WRITE;
      S_WRITE: begin
        // Both channels must accept in the same cycle; no split acceptance.
        if (wr_accept) begin
          if (VERIFY)         state_next = S_RADDR;
          else if (last_word) state_next = S_PULSE;
          else                state_next = S_FETCH;
        end
      end
      S_RADDR: if (arready) state_next = S_RDATA;
      S_RDATA: begin
        if (rvalid) begin
          if (!rd_match)      state_next = S_ERR;
          else if (last_word) state_next = S_PULSE;
          else                state_next = S_FETCH;
        end else if (tmo_hit) begin
          state_next = S_ERR;
        end
      end
      S_PULSE: state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      tmo_reg       <= '0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      ks_tready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      err_index_reg <= '0;
    end else begin
      state_reg <= state_next;

      // Handshake outputs are decoded from the next state so they line up
      // with the state register without a combinational output path.
      ks_tready_reg <= (state_next == S_FETCH);
      awvalid_reg   <= (state_next == S_WRITE);
      wvalid_reg    <= (state_next == S_WRITE);
      arvalid_reg   <= (state_next == S_RADDR);
      rready_reg    <= (state_next == S_RDATA);
      start_reg     <= (state_next == S_PULSE);
      busy_reg      <= (state_next != S_IDLE);

      case (state_reg)
        S_IDLE: begin
          if (load) begin
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            err_index_reg <= '0;
            idx_reg       <= '0;
          end
        end
        S_FETCH: begin
          if (ks_tvalid) begin
            wdata_reg  <= ks_tdata;
            awaddr_reg <= pADDR_WIDTH'(BASE_ADDR)
                        + pADDR_WIDTH'(idx_reg) * pADDR_WIDTH'(ADDR_STRIDE);
          end
        end
        S_WRITE: begin
          if (wr_accept) begin
            if (VERIFY)          araddr_reg <= awaddr_reg;
            else if (!last_word) idx_reg    <= idx_reg + 3'd1;
          end
        end
        S_RADDR: begin
          if (arready) tmo_reg <= '0;
        end
        S_RDATA: begin
          if (rvalid) begin
            if (rd_match && !last_word) idx_reg <= idx_reg + 3'd1;
          end else begin
            tmo_reg <= tmo_reg + TW'(1);
          end
        end
        S_PULSE: done_reg <= 1'b1;
        S_ERR: begin
          error_reg     <= 1'b1;
          err_index_reg <= idx_reg;
        end
        default: ;
      endcase
    end
  end

  assign ks_tready = ks_tready_reg;
  assign awvalid   = awvalid_reg;
  assign wvalid    = wvalid_reg;
  assign arvalid   = arvalid_reg;
  assign rready    = rready_reg;
  assign awaddr    = awaddr_reg;
  assign araddr    = araddr_reg;
  assign wdata     = wdata_reg;
  assign start     = start_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign err_index = err_index_reg;

endmodule
